// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master executing host commands (INIT clocking, CS low, CS high, byte transfer)
//
// Parameters:
//   DIV       SCLK half-period in clocks for byte transfers (1..255)
//   INIT_DIV  SCLK half-period in clocks for the INIT command (1..255)
// Ports:
//   i_clock     system clock, rising edge
//   i_reset     asynchronous active-high reset
//   o_spi_cs    chip select to slave, active low
//   o_spi_sclk  serial clock, idle low
//   i_spi_miso  serial data from slave
//   o_spi_mosi  serial data to slave, idles high
//   i_spi_sent  command strobe from host, rising edge starts i_spi_cmd
//   i_spi_cmd   00 INIT, 01 CS low, 10 CS high, 11 byte transfer
//   o_spi_din   last byte received from slave
//   i_spi_out   byte to transmit on a byte transfer
//   o_spi_st    {timeout, busy}
// Optional feature: define SPI_TIMEOUT_EN to build the timeout flag (received byte 8'hFF);
// without it o_spi_st[1] is tied low.
module spi_master #(
    parameter int DIV      = 2,
    parameter int INIT_DIV = 63
) (
    input  logic       i_clock,
    input  logic       i_reset,
    output logic       o_spi_cs,
    output logic       o_spi_sclk,
    input  logic       i_spi_miso,
    output logic       o_spi_mosi,
    input  logic       i_spi_sent,
    input  logic [1:0] i_spi_cmd,
    output logic [7:0] o_spi_din,
    input  logic [7:0] i_spi_out,
    output logic [1:0] o_spi_st
);
    typedef enum logic [1:0] {IDLE, CSSET, INIT, XFER} state_t;

    localparam logic [7:0] LP_DIV_M1  = 8'(DIV - 1);
    localparam logic [7:0] LP_INIT_M1 = 8'(INIT_DIV - 1);

    state_t     r_state;
    logic       r_sent_s1;
    logic       r_sent_s2;
    logic       r_sent_d;
    logic       r_busy;
    logic       r_cs_val;
    logic [6:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_cnt;
    logic [7:0] r_edge;
    logic       w_rise;
    logic       w_tick;
    logic       w_last;
    logic       w_init;

    assign w_rise = r_sent_s2 & ~r_sent_d;
    assign w_init = (r_state == INIT);
    assign w_tick = (r_cnt == 8'd0);
    // INIT makes 80 pulses (160 toggles), a transfer 8 pulses (16 toggles); the last toggle is always a fall
    assign w_last = (r_edge == (w_init ? 8'd159 : 8'd15));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_sent_s1  <= 1'b0;
            r_sent_s2  <= 1'b0;
            r_sent_d   <= 1'b0;
            r_busy     <= 1'b0;
            r_cs_val   <= 1'b1;
            r_tx       <= 7'd0;
            r_rx       <= 8'd0;
            r_cnt      <= 8'd0;
            r_edge     <= 8'd0;
            o_spi_cs   <= 1'b1;
            o_spi_sclk <= 1'b0;
            o_spi_mosi <= 1'b1;
            o_spi_din  <= 8'd0;
        end else begin
            r_sent_s1 <= i_spi_sent;
            r_sent_s2 <= r_sent_s1;
            r_sent_d  <= r_sent_s2;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_busy   <= 1'b1;
                        r_cs_val <= i_spi_cmd[1];
                        r_tx     <= i_spi_out[6:0];
                        r_edge   <= 8'd0;
                        r_cnt    <= (i_spi_cmd == 2'b00) ? LP_INIT_M1 : LP_DIV_M1;
                        case (i_spi_cmd)
                            2'b00: begin
                                r_state    <= INIT;
                                o_spi_cs   <= 1'b1;
                                o_spi_mosi <= 1'b1;
                            end
                            2'b11: begin
                                r_state    <= XFER;
                                o_spi_mosi <= i_spi_out[7];
                            end
                            default: r_state <= CSSET;
                        endcase
                    end
                end
                CSSET: begin
                    o_spi_cs <= r_cs_val;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                INIT, XFER: begin
                    if (w_tick) begin
                        r_cnt  <= w_init ? LP_INIT_M1 : LP_DIV_M1;
                        r_edge <= r_edge + 8'd1;
                        if (w_last) begin
                            // final fall and completion share one clock so busy lasts exactly 16*DIV / 160*INIT_DIV
                            o_spi_sclk <= 1'b0;
                            o_spi_mosi <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                            if (!w_init) o_spi_din <= r_rx;
                        end else begin
                            o_spi_sclk <= ~o_spi_sclk;
                            if (!w_init && !o_spi_sclk) r_rx <= {r_rx[6:0], i_spi_miso};
                            if (!w_init && o_spi_sclk) begin
                                o_spi_mosi <= r_tx[6];
                                r_tx       <= {r_tx[5:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef SPI_TIMEOUT_EN
    logic r_timeout;
    logic w_accept;
    logic w_done;

    assign w_accept = (r_state == IDLE) & w_rise;
    assign w_done   = (r_state == XFER) & w_tick & w_last;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_timeout <= 1'b0;
        else if (w_accept)
            r_timeout <= 1'b0;
        else if (w_done)
            r_timeout <= (r_rx == 8'hFF);
    end

    assign o_spi_st = {r_timeout, r_busy};
`else
    assign o_spi_st = {1'b0, r_busy};
`endif
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master with a mode-0 slave model
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs;
    logic       spi_sclk;
    logic       spi_miso;
    logic       spi_mosi;
    logic       spi_sent;
    logic [1:0] spi_cmd;
    logic [7:0] spi_din;
    logic [7:0] spi_out;
    logic [1:0] spi_st;

    int checks = 0;
    int errors = 0;

`ifdef SPI_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    spi_master #(.DIV(2), .INIT_DIV(63)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .o_spi_cs   (spi_cs),
        .o_spi_sclk (spi_sclk),
        .i_spi_miso (spi_miso),
        .o_spi_mosi (spi_mosi),
        .i_spi_sent (spi_sent),
        .i_spi_cmd  (spi_cmd),
        .o_spi_din  (spi_din),
        .i_spi_out  (spi_out),
        .o_spi_st   (spi_st)
    );

    always #5 clk = ~clk;

    int         sclk_rises = 0;
    int         sclk_falls = 0;
    int         busy_clks  = 0;
    int         mosi_low   = 0;
    int         slave_base = 0;
    logic [7:0] mosi_sh    = 8'd0;
    logic [7:0] miso_byte  = 8'hFF;
    int         k;

    always @(posedge spi_sclk) begin
        sclk_rises++;
        mosi_sh = {mosi_sh[6:0], spi_mosi};
    end
    always @(negedge spi_sclk) sclk_falls++;
    always @(posedge clk) begin
        if (spi_st[0] === 1'b1) busy_clks++;
        if (spi_st[0] === 1'b1 && spi_mosi !== 1'b1) mosi_low++;
    end

    // mode-0 slave: bit 7 presented up front, next bit after each SCLK fall, idles high afterwards
    always_comb begin
        k = sclk_falls - slave_base;
        spi_miso = (k >= 0 && k < 8) ? miso_byte[3'(7 - k)] : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] cmd, input logic [7:0] out, input int max, input bit glitch);
        int lat;
        int w;
        @(negedge clk);
        spi_cmd  = cmd;
        spi_out  = out;
        spi_sent = 1'b1;
        lat = 0;
        while (spi_st[0] !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("busy_latency_le3", 32'(lat >= 1 && lat <= 3), 32'd1);
        if (glitch) begin
            repeat (200) @(negedge clk);
            spi_sent = 1'b0;
            repeat (5) @(negedge clk);
            spi_sent = 1'b1;
        end
        w = 0;
        while (spi_st[0] !== 1'b0 && w < max) begin
            @(negedge clk);
            w++;
        end
        check("busy_released", 32'(spi_st[0]), 32'd0);
        spi_sent = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int b_busy;
    int b_rise;
    int b_low;

    initial begin
        rst      = 1'b1;
        spi_sent = 1'b0;
        spi_cmd  = 2'b00;
        spi_out  = 8'h00;
        #1;
        check("rst_cs", 32'(spi_cs), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_cs", 32'(spi_cs), 32'd1);
        check("idle_sclk", 32'(spi_sclk), 32'd0);
        check("idle_mosi", 32'(spi_mosi), 32'd1);
        check("idle_din", 32'(spi_din), 32'h00);
        check("idle_st", 32'(spi_st), 32'd0);

        b_busy = busy_clks;
        run(2'b01, 8'h00, 20, 1'b0);
        check("cs_low", 32'(spi_cs), 32'd0);
        check("cs_low_busy_clks", 32'(busy_clks - b_busy), 32'd1);

        slave_base = sclk_falls;
        miso_byte  = 8'h3C;
        b_busy = busy_clks;
        b_rise = sclk_rises;
        run(2'b11, 8'hA5, 100, 1'b0);
        check("xfer1_mosi_bits", 32'(mosi_sh), 32'hA5);
        check("xfer1_pulses", 32'(sclk_rises - b_rise), 32'd8);
        check("xfer1_busy_clks", 32'(busy_clks - b_busy), 32'd32);
        check("xfer1_din", 32'(spi_din), 32'h3C);
        check("xfer1_st", 32'(spi_st), 32'd0);
        check("xfer1_sclk_idle", 32'(spi_sclk), 32'd0);
        check("xfer1_mosi_idle", 32'(spi_mosi), 32'd1);
        check("xfer1_cs_kept", 32'(spi_cs), 32'd0);

        slave_base = sclk_falls;
        miso_byte  = 8'hFF;
        b_rise = sclk_rises;
        run(2'b11, 8'h00, 100, 1'b0);
        check("xfer2_mosi_bits", 32'(mosi_sh), 32'h00);
        check("xfer2_pulses", 32'(sclk_rises - b_rise), 32'd8);
        check("xfer2_din", 32'(spi_din), 32'hFF);
        check("xfer2_timeout", 32'(spi_st[1]), 32'(EXP_TO));

        b_busy = busy_clks;
        run(2'b10, 8'h00, 20, 1'b0);
        check("cs_high", 32'(spi_cs), 32'd1);
        check("cs_high_busy_clks", 32'(busy_clks - b_busy), 32'd1);
        check("timeout_cleared", 32'(spi_st), 32'd0);
        check("din_held", 32'(spi_din), 32'hFF);

        slave_base = sclk_falls;
        miso_byte  = 8'h81;
        run(2'b11, 8'h5A, 100, 1'b0);
        check("xfer3_mosi_bits", 32'(mosi_sh), 32'h5A);
        check("xfer3_din", 32'(spi_din), 32'h81);
        check("xfer3_cs_kept", 32'(spi_cs), 32'd1);
        check("xfer3_st", 32'(spi_st), 32'd0);

        b_busy = busy_clks;
        b_rise = sclk_rises;
        b_low  = mosi_low;
        run(2'b00, 8'h00, 12000, 1'b1);
        check("init_pulses", 32'(sclk_rises - b_rise), 32'd80);
        check("init_busy_clks", 32'(busy_clks - b_busy), 32'd10080);
        check("init_mosi_high", 32'(mosi_low - b_low), 32'd0);
        check("init_cs", 32'(spi_cs), 32'd1);
        check("init_din_held", 32'(spi_din), 32'h81);
        repeat (20) @(negedge clk);
        check("init_no_restart", 32'(spi_st[0]), 32'd0);

        run(2'b01, 8'h00, 20, 1'b0);
        slave_base = sclk_falls;
        miso_byte  = 8'h55;
        @(negedge clk);
        spi_cmd  = 2'b11;
        spi_out  = 8'hFF;
        spi_sent = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_xfer_busy", 32'(spi_st[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_cs", 32'(spi_cs), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_mosi", 32'(spi_mosi), 32'd1);
        check("abort_din", 32'(spi_din), 32'h00);
        check("abort_st", 32'(spi_st), 32'd0);
        spi_sent = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b_rise = sclk_rises;
        repeat (100) @(negedge clk);
        check("post_abort_din", 32'(spi_din), 32'h00);
        check("post_abort_st", 32'(spi_st), 32'd0);
        check("post_abort_no_sclk", 32'(sclk_rises - b_rise), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
